// File: rtl/screen_pkg.sv
// screen_pkg: phase encodings, active video size and RGB packing shared by the VGA path
package screen_pkg;
  typedef enum logic [1:0] {PH_TITLE = 2'd0, PH_PLAY = 2'd1, PH_WIN = 2'd2, PH_LOSE = 2'd3} phase_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer for an asynchronous button plus a one-cycle rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else sr <= {sr[1:0], btn};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: game-phase FSM that muxes renderer RGB onto VGA and gates the game core
module screen_sequencer #(
  parameter int H_ACTIVE = screen_pkg::H_ACTIVE,
  parameter int V_ACTIVE = screen_pkg::V_ACTIVE,
  parameter int HOLD_FRAMES = 120,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        start_btn,
  input  logic        game_won,
  input  logic        game_lost,
  input  logic [23:0] rgb_title,
  input  logic [23:0] rgb_game,
  input  logic [23:0] rgb_win,
  input  logic [23:0] rgb_lose,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        game_enable,
  output logic        game_rst,
  output logic        title_blink,
  output logic [1:0]  phase
);
  import screen_pkg::*;
  phase_t ph, ph_n;
  rgb_t src, pix;
  logic [7:0] frame_cnt, cnt_n;
  logic start_evt, start_pend, pend_n, won_pend, lost_pend;
  logic cond, cond_q, tick, hold_done, allowed, chg, blink_n, vis;
  btn_sync_edge u_start (.clk(clk), .reset(reset), .btn(start_btn), .pulse(start_evt));
  assign cond = h_counter == '0 && v_counter == 10'(V_ACTIVE);
  assign tick = cond & ~cond_q;
  assign hold_done = frame_cnt >= 8'(HOLD_FRAMES);
  assign vis = h_counter < 10'(H_ACTIVE) && v_counter < 10'(V_ACTIVE);
  assign src = ph == PH_TITLE ? rgb_title : ph == PH_PLAY ? rgb_game : ph == PH_WIN ? rgb_win : rgb_lose;
  // Phase only moves on the frame tick, which falls inside vertical blanking.
  always_comb begin
    ph_n = !tick ? ph :
           ph == PH_TITLE ? (start_pend ? PH_PLAY : PH_TITLE) :
           ph == PH_PLAY ? (won_pend ? PH_WIN : lost_pend ? PH_LOSE : PH_PLAY) :
           (start_pend && hold_done) ? PH_TITLE : ph;
    chg = ph_n != ph;
    cnt_n = chg ? 8'd0 : (tick && frame_cnt != 8'hff) ? frame_cnt + 8'd1 : frame_cnt;
    allowed = ph == PH_TITLE || (ph != PH_PLAY && hold_done);
    pend_n = (chg || !allowed) ? 1'b0 : start_pend | start_evt;
    blink_n = ph_n != PH_TITLE ? 1'b0 :
              (tick && !chg && frame_cnt != 8'hff && (32'(cnt_n) % BLINK_FRAMES) == 0) ? ~title_blink : title_blink;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ph <= PH_TITLE;
      frame_cnt <= '0;
      start_pend <= 1'b0;
      won_pend <= 1'b0;
      lost_pend <= 1'b0;
      cond_q <= 1'b0;
      title_blink <= 1'b0;
      game_enable <= 1'b0;
      game_rst <= 1'b0;
      pix <= '0;
    end else begin
      ph <= ph_n;
      frame_cnt <= cnt_n;
      start_pend <= pend_n;
      won_pend <= !chg && (won_pend || (ph == PH_PLAY && game_won));
      lost_pend <= !chg && (lost_pend || (ph == PH_PLAY && game_lost));
      cond_q <= cond;
      title_blink <= blink_n;
      game_enable <= ph_n == PH_PLAY;
      game_rst <= chg && ph_n == PH_PLAY;
      pix <= vis ? src : '0;
    end
  assign R = pix.r;
  assign G = pix.g;
  assign B = pix.b;
  assign phase = ph;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: scoreboard bench driving compressed VGA frames through the screen phases
module tb_screen_sequencer;
  localparam logic [23:0] C_TITLE = 24'h102030;
  localparam logic [23:0] C_GAME = 24'h405060;
  localparam logic [23:0] C_WIN = 24'h708090;
  localparam logic [23:0] C_LOSE = 24'ha0b0c0;
  logic clk = 1'b0, reset = 1'b0, start_btn = 1'b0, game_won = 1'b0, game_lost = 1'b0;
  logic [9:0] h_counter = '0, v_counter = '0;
  logic [23:0] rgb_title = C_TITLE, rgb_game = C_GAME, rgb_win = C_WIN, rgb_lose = C_LOSE;
  logic [7:0] R, G, B;
  logic game_enable, game_rst, title_blink;
  logic [1:0] phase;
  logic [23:0] sb[$];
  int total = 0, bad = 0, exp_ph = 0, rst_pulses = 0;
  screen_sequencer dut (
    .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
    .start_btn(start_btn), .game_won(game_won), .game_lost(game_lost),
    .rgb_title(rgb_title), .rgb_game(rgb_game), .rgb_win(rgb_win), .rgb_lose(rgb_lose),
    .R(R), .G(G), .B(B), .game_enable(game_enable), .game_rst(game_rst),
    .title_blink(title_blink), .phase(phase)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (game_rst) rst_pulses++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [23:0] exp_pix(input int h, input int v);
    if (h >= 640 || v >= 480) return 24'h0;
    return exp_ph == 0 ? C_TITLE : exp_ph == 1 ? C_GAME : exp_ph == 2 ? C_WIN : C_LOSE;
  endfunction
  // One compressed frame: a few columns on a few lines, with the frame tick at (0,480).
  task automatic frame(input int press_v, input int lose_v, input int rst_v);
    int vl[8] = '{0, 100, 200, 240, 479, 480, 500, 524};
    int hl[6] = '{0, 1, 320, 639, 640, 700};
    foreach (vl[i]) foreach (hl[j]) begin
      @(negedge clk);
      if (sb.size() > 0) chk("rgb", {R, G, B}, sb.pop_front());
      if (vl[i] == 479 && hl[j] == 700) chk("phase_pre_tick", phase, exp_ph);
      start_btn = vl[i] == press_v && hl[j] <= 320;
      if (vl[i] == lose_v) game_lost = 1'b1;
      h_counter = 10'(hl[j]);
      v_counter = 10'(vl[i]);
      sb.push_back(exp_pix(hl[j], vl[i]));
      if (vl[i] == rst_v && hl[j] == 320) begin
        #2 reset = 1'b0;
        #1 chk("rst_rgb", {R, G, B}, 0);
        chk("rst_phase", phase, 0);
        sb.delete();
        exp_ph = 0;
        @(negedge clk) reset = 1'b1;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_phase", phase, 0);
    chk("reset_rgb", {R, G, B}, 0);
    chk("reset_enable", game_enable, 0);
    chk("reset_game_rst", game_rst, 0);
    chk("reset_blink", title_blink, 0);
    reset = 1'b1;
    for (int f = 1; f <= 30; f++) begin
      frame(-1, -1, -1);
      if (f == 3) chk("title_phase", phase, 0);
      if (f == 29) chk("blink_before", title_blink, 0);
      if (f == 30) chk("blink_after", title_blink, 1);
    end
    rst_pulses = 0;
    frame(100, -1, -1);
    exp_ph = 1;
    chk("play_phase", phase, 1);
    chk("play_enable", game_enable, 1);
    chk("play_game_rst_once", rst_pulses, 1);
    chk("play_blink", title_blink, 0);
    frame(100, -1, -1);
    chk("play_start_ignored", phase, 1);
    chk("game_rst_no_repeat", rst_pulses, 1);
    game_won = 1'b1;
    game_lost = 1'b1;
    frame(-1, -1, -1);
    exp_ph = 2;
    chk("win_priority", phase, 2);
    chk("win_enable", game_enable, 0);
    game_won = 1'b0;
    game_lost = 1'b0;
    for (int n = 1; n <= 121; n++) begin
      frame((n == 50 || n == 120 || n == 121) ? 100 : -1, -1, -1);
      if (n == 50) chk("win_early_start", phase, 2);
      if (n == 51) chk("win_not_queued", phase, 2);
      if (n == 120) chk("win_hold_edge", phase, 2);
      if (n == 121) begin
        exp_ph = 0;
        chk("win_to_title", phase, 0);
      end
    end
    frame(100, -1, -1);
    exp_ph = 1;
    chk("replay_phase", phase, 1);
    frame(-1, 200, -1);
    exp_ph = 3;
    chk("lose_phase", phase, 3);
    chk("lose_enable", game_enable, 0);
    frame(-1, -1, 240);
    game_lost = 1'b0;
    chk("post_reset_phase", phase, 0);
    frame(-1, -1, -1);
    chk("title_again", phase, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
